// File: rtl/counter_cell_seq.sv
// Involuntary-counter sequencer: latches per-channel up/down increment requests and grants
// the lowest pending channel one timed counter cycle, with DINC sign reporting at the end.
//
// state | meaning
// IDLE  | no cycle running; a grant (ack) can fire here when slot_avail and a channel is pending
// RUN   | counter cycle in progress, timepulse t_q = 1..CYC_LEN
module counter_cell_seq #(
  parameter int NCH = 20,
  parameter int AW = 5,
  parameter int CTR_BASE = 0,
  parameter int CYC_LEN = 12,
  parameter int OP_T = 6,
  parameter logic [NCH-1:0] DINC_MASK = '0,
  parameter logic [NCH-1:0] CDU_MASK = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           gojam,
  input  logic [NCH-1:0] req_up,
  input  logic [NCH-1:0] req_dn,
  input  logic           slot_avail,
  input  logic           dinc_zero,
  input  logic           dinc_neg,
  output logic           inkl,
  output logic [AW-1:0]  ctr_addr,
  output logic [2:0]     op,
  output logic           op_pulse,
  output logic           zout,
  output logic           pout,
  output logic           mout,
  output logic [NCH-1:0] ack,
  output logic           overrun
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(CYC_LEN + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CYC_LEN);
  localparam logic [TW-1:0] T_PRE  = TW'(CYC_LEN - 1);
  localparam logic [TW-1:0] T_OP   = TW'(OP_T);
  localparam logic [TW-1:0] T_SAMP = TW'(OP_T + 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PINC = 3'd1;
  localparam logic [2:0] OP_MINC = 3'd2;
  localparam logic [2:0] OP_PCDU = 3'd3;
  localparam logic [2:0] OP_MCDU = 3'd4;
  localparam logic [2:0] OP_DINC = 3'd5;

  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("counter_cell_seq: NCH must be in 1..32");
  end
  if (CTR_BASE + NCH > 2**AW) begin : g_bad_aw
    $error("counter_cell_seq: CTR_BASE+NCH exceeds the 2**AW address space");
  end
  if (CYC_LEN < 4 || OP_T < 2 || OP_T > CYC_LEN - 2) begin : g_bad_timing
    $error("counter_cell_seq: need CYC_LEN >= 4 and 2 <= OP_T <= CYC_LEN-2");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic [TW-1:0]   t_nxt;
  logic [NCH-1:0]  up_q, up_d;
  logic [NCH-1:0]  dn_q, dn_d;
  logic [NCH-1:0]  dn_eff;
  logic [NCH-1:0]  sel;
  logic            ovr_d;
  logic            any_pend;
  logic            grant;
  logic [IW-1:0]   gidx;
  logic [2:0]      gop;
  logic            zs_q, ns_q;
  logic            zero_eff, neg_eff;
  logic            inkl_q, op_pulse_q, zout_q, pout_q, mout_q, overrun_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      op_q;

  // Down requests have no meaning on DINC channels.
  assign dn_eff   = req_dn & ~DINC_MASK;
  assign any_pend = |(up_q | dn_q);
  assign grant    = (state_q == S_IDLE) && slot_avail && any_pend && !gojam && !rst;
  assign ack      = grant ? sel : '0;
  assign t_nxt    = t_q + T_ONE;

  always_comb begin
    sel  = '0;
    gidx = '0;
    gop  = OP_NONE;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (up_q[i] || dn_q[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
        gidx   = IW'(i);
        if (DINC_MASK[i])  gop = OP_DINC;
        else if (CDU_MASK[i]) gop = up_q[i] ? OP_PCDU : OP_MCDU;
        else               gop = up_q[i] ? OP_PINC : OP_MINC;
      end
    end
  end

  // Requests are resolved against the post-grant state, so a same-clock request re-latches.
  always_comb begin
    up_d  = up_q;
    dn_d  = dn_q;
    ovr_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ack[i]) begin
        if (up_q[i]) up_d[i] = 1'b0;
        else         dn_d[i] = 1'b0;
      end
      if (req_up[i] && !dn_eff[i]) begin
        if (dn_d[i]) dn_d[i] = 1'b0;
        else begin
          ovr_d   = ovr_d | up_d[i];
          up_d[i] = 1'b1;
        end
      end else if (dn_eff[i] && !req_up[i]) begin
        if (up_d[i]) up_d[i] = 1'b0;
        else begin
          ovr_d   = ovr_d | dn_d[i];
          dn_d[i] = 1'b1;
        end
      end
    end
  end

  // The sample clock and the result-compute clock coincide when OP_T+1 == CYC_LEN-1.
  assign zero_eff = (t_q == T_SAMP) ? dinc_zero : zs_q;
  assign neg_eff  = (t_q == T_SAMP) ? dinc_neg  : ns_q;

  always_ff @(posedge clk) begin
    if (rst || gojam) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      up_q       <= '0;
      dn_q       <= '0;
      inkl_q     <= 1'b0;
      addr_q     <= '0;
      op_q       <= OP_NONE;
      op_pulse_q <= 1'b0;
      zout_q     <= 1'b0;
      pout_q     <= 1'b0;
      mout_q     <= 1'b0;
      overrun_q  <= 1'b0;
      zs_q       <= 1'b0;
      ns_q       <= 1'b0;
    end else begin
      up_q       <= up_d;
      dn_q       <= dn_d;
      overrun_q  <= ovr_d;
      op_pulse_q <= 1'b0;
      zout_q     <= 1'b0;
      pout_q     <= 1'b0;
      mout_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            state_q <= S_RUN;
            t_q     <= T_ONE;
            inkl_q  <= 1'b1;
            addr_q  <= AW'(CTR_BASE) + AW'(gidx);
            op_q    <= gop;
          end
        end
        S_RUN: begin
          if (t_q == T_LAST) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            inkl_q  <= 1'b0;
            addr_q  <= '0;
            op_q    <= OP_NONE;
          end else begin
            t_q        <= t_nxt;
            op_pulse_q <= (t_nxt == T_OP);
            if (t_q == T_SAMP) begin
              zs_q <= dinc_zero;
              ns_q <= dinc_neg;
            end
            if (t_q == T_PRE && op_q == OP_DINC) begin
              zout_q <= zero_eff;
              mout_q <= !zero_eff && neg_eff;
              pout_q <= !zero_eff && !neg_eff;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inkl     = inkl_q;
  assign ctr_addr = addr_q;
  assign op       = op_q;
  assign op_pulse = op_pulse_q;
  assign zout     = zout_q;
  assign pout     = pout_q;
  assign mout     = mout_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_counter_cell_seq.sv
// Scoreboard bench for counter_cell_seq: a mode/mask instance at default timing and a
// wide instance with short cycles; expected counter cycles are queued at stimulus time.
module tb_counter_cell_seq;
  localparam int NA = 20, AWA = 5, CYA = 12, OPA = 6;
  localparam int NB = 32, AWB = 6, BASEB = 8, CYB = 4, OPB = 2;

  typedef struct {
    int ch;
    int addr;
    int op;
    int res;      // {zout,pout,mout} expected at t==CYC_LEN
    int ack_cyc;
    int abort_t;  // 0: runs to completion
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           a_gojam, a_slot, a_dz, a_dng;
  logic [NA-1:0]  a_up, a_dn, a_ack;
  logic           a_inkl, a_opp, a_z, a_p, a_m, a_ovr;
  logic [AWA-1:0] a_addr;
  logic [2:0]     a_op;

  logic           b_gojam, b_slot, b_dz, b_dng;
  logic [NB-1:0]  b_up, b_dn, b_ack;
  logic           b_inkl, b_opp, b_z, b_p, b_m, b_ovr;
  logic [AWB-1:0] b_addr;
  logic [2:0]     b_op;

  counter_cell_seq #(
    .NCH(NA), .AW(AWA), .CTR_BASE(0), .CYC_LEN(CYA), .OP_T(OPA),
    .DINC_MASK(20'h00020), .CDU_MASK(20'h00010)
  ) dut_a (
    .clk(clk), .rst(rst), .gojam(a_gojam), .req_up(a_up), .req_dn(a_dn),
    .slot_avail(a_slot), .dinc_zero(a_dz), .dinc_neg(a_dng), .inkl(a_inkl),
    .ctr_addr(a_addr), .op(a_op), .op_pulse(a_opp), .zout(a_z), .pout(a_p),
    .mout(a_m), .ack(a_ack), .overrun(a_ovr)
  );

  counter_cell_seq #(
    .NCH(NB), .AW(AWB), .CTR_BASE(BASEB), .CYC_LEN(CYB), .OP_T(OPB),
    .DINC_MASK(32'h0), .CDU_MASK(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst), .gojam(b_gojam), .req_up(b_up), .req_dn(b_dn),
    .slot_avail(b_slot), .dinc_zero(b_dz), .dinc_neg(b_dng), .inkl(b_inkl),
    .ctr_addr(b_addr), .op(b_op), .op_pulse(b_opp), .zout(b_z), .pout(b_p),
    .mout(b_m), .ack(b_ack), .overrun(b_ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (clock %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic run_chk(input string p, input int tt, input int clen, input int opt,
                         input exp_t e, input logic inkl, input int addr, input int opv,
                         input logic opp, input logic [2:0] res);
    chk({p, "_inkl"}, 64'(inkl), 64'd1);
    chk({p, "_addr"}, 64'(addr), 64'(e.addr));
    chk({p, "_op"}, 64'(opv), 64'(e.op));
    chk({p, "_op_pulse"}, 64'(opp), 64'(tt == opt));
    chk({p, "_result"}, 64'(res), (tt == clen) ? 64'(e.res) : 64'd0);
  endtask

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a, cur_b;
  int   tt_a = 0, tt_b = 0;
  bit   gap_a = 1'b0, gap_b = 1'b0;

  always @(negedge clk) begin
    if (tt_a == 0) begin
      if (gap_a) begin
        chk("a_gap_inkl", 64'(a_inkl), 64'd0);
        gap_a = 1'b0;
      end
      if (a_ack != '0) begin
        if (qa.size() == 0) chk("a_unexpected_ack", 64'(a_ack), 64'd0);
        else begin
          cur_a = qa.pop_front();
          chk("a_ack", 64'(a_ack), 64'(1) << cur_a.ch);
          chk("a_ack_cyc", 64'(cyc), 64'(cur_a.ack_cyc));
          tt_a = 1;
        end
      end
    end else if (cur_a.abort_t != 0 && tt_a > cur_a.abort_t) begin
      chk("a_abort_outs", 64'({a_inkl, a_addr, a_op, a_opp, a_z, a_p, a_m, a_ack, a_ovr}), 64'd0);
      tt_a = 0;
    end else begin
      run_chk("a", tt_a, CYA, OPA, cur_a, a_inkl, int'(a_addr), int'(a_op), a_opp, {a_z, a_p, a_m});
      chk("a_run_ack", 64'(a_ack), 64'd0);
      if (tt_a == CYA) begin
        tt_a  = 0;
        gap_a = 1'b1;
      end else tt_a++;
    end
  end

  always @(negedge clk) begin
    if (tt_b == 0) begin
      if (gap_b) begin
        chk("b_gap_inkl", 64'(b_inkl), 64'd0);
        gap_b = 1'b0;
      end
      if (b_ack != '0) begin
        if (qb.size() == 0) chk("b_unexpected_ack", 64'(b_ack), 64'd0);
        else begin
          cur_b = qb.pop_front();
          chk("b_ack", 64'(b_ack), 64'(1) << cur_b.ch);
          chk("b_ack_cyc", 64'(cyc), 64'(cur_b.ack_cyc));
          tt_b = 1;
        end
      end
    end else begin
      run_chk("b", tt_b, CYB, OPB, cur_b, b_inkl, int'(b_addr), int'(b_op), b_opp, {b_z, b_p, b_m});
      chk("b_run_ack", 64'(b_ack), 64'd0);
      if (tt_b == CYB) begin
        tt_b  = 0;
        gap_b = 1'b1;
      end else tt_b++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (!(qa.size() == 0 && tt_a == 0 && !gap_a && qb.size() == 0 && tt_b == 0 && !gap_b)
           && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_drained"}, 64'(k < 300), 64'd1);
    if (k >= 300) begin
      qa.delete();
      qb.delete();
    end
    step();
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen = seen | (|a_ack) | a_inkl | (|b_ack) | b_inkl;
    end
    step();
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic dinc_run(input int res, input logic z7, input logic n7,
                          input logic zdef, input logic ndef);
    a_dz  = zdef;
    a_dng = ndef;
    a_up[5] = 1'b1;
    qa.push_back('{5, 5, 5, res, cyc + 1, 0});
    step();
    a_up = '0;
    repeat (7) step();
    a_dz  = z7;
    a_dng = n7;
    step();
    a_dz  = zdef;
    a_dng = ndef;
    wait_idle("dinc");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_gojam = 0; a_slot = 0; a_dz = 0; a_dng = 0; a_up = '0; a_dn = '0;
    b_gojam = 0; b_slot = 0; b_dz = 0; b_dng = 0; b_up = '0; b_dn = '0;
    rst = 1'b1;
    repeat (3) step();
    a_up[2] = 1'b1;
    b_up[5] = 1'b1;
    step();
    rst = 1'b0;
    a_up = '0;
    b_up = '0;
    a_slot = 1'b1;
    b_slot = 1'b1;
    @(negedge clk);
    chk("a_reset_outs", 64'({a_inkl, a_addr, a_op, a_opp, a_z, a_p, a_m, a_ack, a_ovr}), 64'd0);
    chk("b_reset_outs", 64'({b_inkl, b_addr, b_op, b_opp, b_z, b_p, b_m, b_ack, b_ovr}), 64'd0);
    step();
    expect_quiet("rst_clock_req_discarded", 5);

    a_up[3] = 1'b1;
    qa.push_back('{3, 3, 1, 0, cyc + 1, 0});
    step();
    a_up = '0;
    wait_idle("pinc");

    a_up[7] = 1'b1;
    a_dn[2] = 1'b1;
    qa.push_back('{2, 2, 2, 0, cyc + 1, 0});
    qa.push_back('{7, 7, 1, 0, cyc + 14, 0});
    step();
    a_up = '0;
    a_dn = '0;
    wait_idle("priority");

    a_dn[4] = 1'b1;
    qa.push_back('{4, 4, 4, 0, cyc + 1, 0});
    step();
    a_dn = '0;
    wait_idle("mcdu");
    a_up[4] = 1'b1;
    qa.push_back('{4, 4, 3, 0, cyc + 1, 0});
    step();
    a_up = '0;
    wait_idle("pcdu");

    a_dn[5] = 1'b1;
    step();
    a_dn = '0;
    expect_quiet("dinc_dn_ignored", 4);

    dinc_run(1, 1'b0, 1'b1, 1'b1, 1'b0);
    dinc_run(4, 1'b1, 1'b0, 1'b0, 1'b1);
    dinc_run(2, 1'b0, 1'b0, 1'b1, 1'b1);
    a_dz  = 1'b0;
    a_dng = 1'b0;

    a_up[1] = 1'b1;
    a_dn[1] = 1'b1;
    step();
    a_up = '0;
    a_dn = '0;
    expect_quiet("same_clock_cancel", 4);

    a_slot = 1'b0;
    a_up[1] = 1'b1;
    step();
    @(negedge clk);
    chk("overrun_first_req", 64'(a_ovr), 64'd0);
    step();
    a_up = '0;
    @(negedge clk);
    chk("overrun_second_req", 64'(a_ovr), 64'd1);
    step();
    @(negedge clk);
    chk("overrun_one_clock", 64'(a_ovr), 64'd0);
    step();
    a_slot = 1'b1;
    qa.push_back('{1, 1, 1, 0, cyc, 0});
    wait_idle("overrun_grant");
    expect_quiet("overrun_single_ack", 4);

    a_slot = 1'b0;
    a_up[1] = 1'b1;
    step();
    a_up = '0;
    a_dn[1] = 1'b1;
    step();
    a_dn = '0;
    a_slot = 1'b1;
    expect_quiet("opposite_cancel", 4);

    a_slot = 1'b0;
    a_up[6] = 1'b1;
    step();
    a_slot = 1'b1;
    qa.push_back('{6, 6, 1, 0, cyc, 0});
    qa.push_back('{6, 6, 1, 0, cyc + 13, 0});
    step();
    a_up = '0;
    wait_idle("grant_clock_relatch");

    a_slot = 1'b0;
    a_up[0] = 1'b1;
    a_up[9] = 1'b1;
    step();
    a_up = '0;
    a_slot = 1'b1;
    qa.push_back('{0, 0, 1, 0, cyc, 5});
    repeat (5) step();
    a_gojam = 1'b1;
    a_up[11] = 1'b1;
    step();
    a_gojam = 1'b0;
    a_up = '0;
    expect_quiet("gojam_pending_cleared", 20);
    wait_idle("gojam");

    b_up[31] = 1'b1;
    qb.push_back('{31, 39, 1, 0, cyc + 1, 0});
    step();
    b_up = '0;
    wait_idle("sweep_single");
    b_up[31] = 1'b1;
    b_dn[0] = 1'b1;
    qb.push_back('{0, 8, 2, 0, cyc + 1, 0});
    qb.push_back('{31, 39, 1, 0, cyc + 6, 0});
    step();
    b_up = '0;
    b_dn = '0;
    wait_idle("sweep_b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
